audio_feed: RTL and testbench

Sample feeder FIFO that sits directly upstream of the PCM/I2S audio serializer and drives its 16-bit `d_in`. Producers (microphone capture, sample generator, CPU port) push 16-bit PCM words through a valid/ready write port. The FIFO pops one word each time the serializer signals `done`. On underflow it substitutes silence and raises a sticky flag.

---
 rtl/audio_feed.sv | 179 +++++++++++++++++
 tb/tb_audio_feed.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_feed.sv
// ============================================================================
// audio_feed
// ----------------------------------------------------------------------------
// Sample feeder FIFO that sits directly upstream of the PCM/I2S audio
// serializer and drives its 16-bit d_in. Producers push signed 16-bit PCM
// words through a valid/ready write port. One word is popped on every rising
// edge of the serializer's done level. When a pop is requested and the FIFO
// is empty, silence (16'h0000) is presented instead and a sticky underflow
// flag is raised.
//
// Parameters
//   DEPTH_LOG2    FIFO depth is 2**DEPTH_LOG2 words (legal range 2..8)
//
// Ports
//   clk           system clock (also feeds the serializer's divider)
//   reset         synchronous, active-high reset
//   enable        1 = read events honoured, 0 = feeder paused
//   wr_valid      producer has a word
//   wr_data       signed two's-complement PCM word
//   wr_ready      FIFO accepts a word this cycle
//   done          serializer done level, sampled in clk
//   sample        word presented to the serializer d_in
//   sample_valid  1 = sample holds popped data, 0 = substituted silence
//   underflow     sticky underflow flag, cleared only by reset
//   level         current occupancy, 0..2**DEPTH_LOG2
//   uflow_cnt     saturating underflow event counter (optional)
//
// Build options
//   AUDIO_FEED_UFLOW_CNT_EN  when defined, adds the uflow_cnt port and its
//                            16-bit saturating counter. When undefined the
//                            port and counter do not exist; all other
//                            behaviour is identical.
// ============================================================================
module audio_feed #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  wr_valid,
   input  logic [15:0]           wr_data,
   output logic                  wr_ready,
   input  logic                  done,
   output logic [15:0]           sample,
   output logic                  sample_valid,
   output logic                  underflow,
   output logic [DEPTH_LOG2:0]   level
`ifdef AUDIO_FEED_UFLOW_CNT_EN
   ,
   output logic [15:0]           uflow_cnt
`endif
);

   localparam int                 DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [15:0]        SILENCE    = 16'h0000;

   // Storage and pointers. The pointers are exactly DEPTH_LOG2 bits wide so
   // they wrap modulo the depth on their own; occupancy is tracked by the
   // separate level counter, which removes any full/empty ambiguity.
   logic [15:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;

   logic done_q;
   logic rd_evt;
   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;

   // Occupancy decode and write handshake. wr_ready is forced low while
   // reset is asserted so nothing is accepted in the cycle that clears the
   // FIFO, even if the producer is holding wr_valid high.
   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == LEVEL_FULL);
   assign wr_ready   = !reset && !fifo_full;
   assign push       = wr_valid && wr_ready;

   // done is a level generated from the serializer's bit clock domain. Only
   // its rising edge means "the serializer just latched d_in, give it the
   // next word", so a long high level yields a single event. While enable is
   // low the edge is dropped on the floor rather than remembered, because
   // done_q keeps tracking done regardless of enable.
   assign rd_evt = done && !done_q && enable;

   // A pop only happens when there is something to pop. An event against an
   // empty FIFO is an underflow and leaves both pointers alone. There is no
   // bypass: a word written in the same cycle as an underflowing event is
   // stored normally and becomes the next word popped.
   assign pop = rd_evt && !fifo_empty;

   // Sample storage write port. The array is deliberately not reset: a
   // reset empties the FIFO through the level counter and pointers, and the
   // stale contents can never be read before they are overwritten.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Edge detector history. Cleared by reset so that a done level which is
   // already high in the cycle reset drops is seen as a fresh rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done;
      end
   end

   // Pointer advance. A push and a pop in the same cycle move both pointers
   // independently; they can never address the same slot at once because a
   // push is refused when full and a pop is refused when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy counter. A simultaneous push and pop cancel out. The empty
   // and full corner cases fall out naturally: when empty, pop is already
   // suppressed, so only the push counts; when full, push is suppressed by
   // wr_ready, so only the pop counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Output register feeding the serializer. It only changes on a read
   // event; between events the serializer keeps seeing the last word. On an
   // underflowing event silence is substituted, sample_valid drops so the
   // downstream can tell real data from filler, and the sticky flag is set.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample       <= SILENCE;
         sample_valid <= 1'b0;
         underflow    <= 1'b0;
      end else if (rd_evt) begin
         if (fifo_empty) begin
            sample       <= SILENCE;
            sample_valid <= 1'b0;
            underflow    <= 1'b1;
         end else begin
            sample       <= mem[rd_ptr];
            sample_valid <= 1'b1;
         end
      end
   end

`ifdef AUDIO_FEED_UFLOW_CNT_EN
   // Underflow event counter. It counts every underflowing read event, not
   // just the first one, and parks at all-ones instead of wrapping so that a
   // long starvation period can never read back as a small number.
   always_ff @(posedge clk) begin
      if (reset) begin
         uflow_cnt <= 16'h0000;
      end else if (rd_evt && fifo_empty && (uflow_cnt != 16'hFFFF)) begin
         uflow_cnt <= uflow_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_audio_feed.sv
// ============================================================================
// tb_audio_feed
// ----------------------------------------------------------------------------
// Self-checking bench for audio_feed with DEPTH_LOG2 = 4. A cycle-level
// reference model (a queue of stored words plus edge-detect history) decides
// what each driven cycle should do; every predicted read event pushes its
// expected sample/sample_valid pair into a scoreboard queue, which the test
// tasks pop and compare once the DUT has produced the output one edge later.
// ============================================================================
module tb_audio_feed;

   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic        done;
   logic [15:0] sample;
   logic        sample_valid;
   logic        underflow;
   logic [DEPTH_LOG2:0] level;
`ifdef AUDIO_FEED_UFLOW_CNT_EN
   logic [15:0] uflow_cnt;
`endif

   audio_feed #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .done         (done),
      .sample       (sample),
      .sample_valid (sample_valid),
      .underflow    (underflow),
      .level        (level)
`ifdef AUDIO_FEED_UFLOW_CNT_EN
      ,
      .uflow_cnt    (uflow_cnt)
`endif
   );

   // 100 MHz style free-running clock
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] s;
      logic        v;
   } exp_t;

   logic [15:0] model_q[$];
   exp_t        exp_q[$];
   logic        done_prev = 1'b0;
   logic        m_uflow   = 1'b0;
   int          m_ucnt    = 0;
   logic        last_evt  = 1'b0;
   logic [15:0] m_sample  = 16'h0000;
   logic        m_valid   = 1'b0;

   int checks   = 0;
   int failures = 0;

   // Drives one clock cycle of stimulus, advances the reference model with
   // the same inputs, then waits for the edge and lets outputs settle.
   task automatic drive_cycle(input logic v, input logic [15:0] d,
                              input logic dn, input logic en, input logic rst);
      logic evt;
      logic acc;
      wr_valid = v;
      wr_data  = d;
      done     = dn;
      enable   = en;
      reset    = rst;
      if (rst) begin
         model_q.delete();
         exp_q.delete();
         m_uflow   = 1'b0;
         m_ucnt    = 0;
         done_prev = 1'b0;
         last_evt  = 1'b0;
         m_sample  = 16'h0000;
         m_valid   = 1'b0;
      end else begin
         acc = v && (model_q.size() < DEPTH);
         evt = dn && !done_prev && en;
         if (evt) begin
            if (model_q.size() > 0) begin
               m_sample = model_q.pop_front();
               m_valid  = 1'b1;
            end else begin
               m_sample = 16'h0000;
               m_valid  = 1'b0;
               m_uflow  = 1'b1;
               if (m_ucnt < 65535) m_ucnt++;
            end
            exp_q.push_back('{s: m_sample, v: m_valid});
         end
         if (acc) model_q.push_back(d);
         done_prev = dn;
         last_evt  = evt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive_cycle(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
      checks++;
      if (wr_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_wr_ready got=%b exp=0", wr_ready);
      end
      checks++;
      if (level !== 5'd0 || sample !== 16'h0000 || sample_valid !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state got level=%0d sample=%h valid=%b uflow=%b exp 0/0000/0/0",
                  level, sample, sample_valid, underflow);
      end
`ifdef AUDIO_FEED_UFLOW_CNT_EN
      checks++;
      if (uflow_cnt !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_uflow_cnt got=%h exp=0000", uflow_cnt);
      end
`endif
      reset    = 1'b0;
      wr_valid = 1'b0;
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL release_wr_ready got=%b exp=1", wr_ready);
      end
   endtask

   task automatic test_fill_drain();
      exp_t e;
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b1, 16'(i + 1), 1'b0, 1'b1, 1'b0);
         checks++;
         if (level !== 5'(i + 1)) begin
            failures++;
            $display("[TB] FAIL fill_level got=%0d exp=%0d", level, i + 1);
         end
      end
      checks++;
      if (wr_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_wr_ready got=%b exp=0", wr_ready);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (sample !== e.s || sample_valid !== e.v) begin
            failures++;
            $display("[TB] FAIL drain_data got=%h/%b exp=%h/%b", sample, sample_valid, e.s, e.v);
         end
         checks++;
         if (level !== 5'(DEPTH - 1 - i)) begin
            failures++;
            $display("[TB] FAIL drain_level got=%0d exp=%0d", level, DEPTH - 1 - i);
         end
         drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_underflow();
      exp_t e;
      drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (sample !== e.s || sample_valid !== e.v || underflow !== 1'b1) begin
         failures++;
         $display("[TB] FAIL uflow_event got=%h/%b/%b exp=%h/%b/1", sample, sample_valid, underflow, e.s, e.v);
      end
`ifdef AUDIO_FEED_UFLOW_CNT_EN
      checks++;
      if (uflow_cnt !== 16'd1) begin
         failures++;
         $display("[TB] FAIL uflow_cnt_first got=%0d exp=1", uflow_cnt);
      end
`endif
      drive_cycle(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (sample !== e.s || sample_valid !== e.v || underflow !== 1'b1) begin
         failures++;
         $display("[TB] FAIL uflow_recover got=%h/%b/%b exp=%h/%b/1", sample, sample_valid, underflow, e.s, e.v);
      end
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_long_done_enable();
      exp_t e;
      int   pops;
      drive_cycle(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
      pops = 0;
      for (int i = 0; i < 50; i++) begin
         drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
         if (last_evt) begin
            pops++;
            e = exp_q.pop_front();
            checks++;
            if (sample !== e.s || sample_valid !== e.v) begin
               failures++;
               $display("[TB] FAIL long_done_data got=%h/%b exp=%h/%b", sample, sample_valid, e.s, e.v);
            end
         end
      end
      checks++;
      if (level !== 5'd2 || sample !== 16'h1111 || pops != 1) begin
         failures++;
         $display("[TB] FAIL long_done_single got level=%0d sample=%h exp level=2 sample=1111", level, sample);
      end
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
         drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
         checks++;
         if (level !== 5'd2 || sample !== 16'h1111 || sample_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL disabled_hold got level=%0d sample=%h/%b exp 2/1111/1", level, sample, sample_valid);
         end
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      for (int i = 0; i < DEPTH - 2; i++) begin
         drive_cycle(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (level !== 5'd16) begin
         failures++;
         $display("[TB] FAIL refill_level got=%0d exp=16", level);
      end
      drive_cycle(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (level !== 5'd15 || sample !== e.s || sample_valid !== e.v) begin
         failures++;
         $display("[TB] FAIL full_push_pop got level=%0d sample=%h exp level=15 sample=%h", level, sample, e.s);
      end
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (sample !== e.s || sample_valid !== e.v) begin
            failures++;
            $display("[TB] FAIL full_drain_data got=%h/%b exp=%h/%b", sample, sample_valid, e.s, e.v);
         end
         drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      end
      drive_cycle(1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (sample !== e.s || sample_valid !== e.v || underflow !== 1'b1 || level !== 5'd1) begin
         failures++;
         $display("[TB] FAIL empty_push_pop got %h/%b/%b level=%0d exp %h/%b/1 level=1",
                  sample, sample_valid, underflow, level, e.s, e.v);
      end
`ifdef AUDIO_FEED_UFLOW_CNT_EN
      checks++;
      if (uflow_cnt !== 16'(m_ucnt)) begin
         failures++;
         $display("[TB] FAIL uflow_cnt_second got=%0d exp=%0d", uflow_cnt, m_ucnt);
      end
`endif
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (sample !== e.s || sample_valid !== e.v || e.s !== 16'hCAFE) begin
         failures++;
         $display("[TB] FAIL stored_after_uflow got=%h/%b exp=CAFE/1", sample, sample_valid);
      end
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_wrap_and_reset();
      exp_t e;
      for (int i = 0; i < 120; i++) begin
         drive_cycle((i < 60) && (i % 3 != 2), 16'($urandom), (i % 3 == 1), 1'b1, 1'b0);
         if (last_evt) begin
            e = exp_q.pop_front();
            checks++;
            if (sample !== e.s || sample_valid !== e.v) begin
               failures++;
               $display("[TB] FAIL wrap_data cycle=%0d got=%h/%b exp=%h/%b", i, sample, sample_valid, e.s, e.v);
            end
         end
         checks++;
         if (level !== 5'(model_q.size()) || underflow !== m_uflow) begin
            failures++;
            $display("[TB] FAIL wrap_level cycle=%0d got=%0d/%b exp=%0d/%b", i, level, underflow, model_q.size(), m_uflow);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (level !== 5'd5) begin
         failures++;
         $display("[TB] FAIL pre_reset_level got=%0d exp=5", level);
      end
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      checks++;
      if (level !== 5'd0 || underflow !== 1'b0 || sample_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrun_reset got level=%0d uflow=%b valid=%b exp 0/0/0", level, underflow, sample_valid);
      end
      drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (sample !== e.s || sample_valid !== e.v || underflow !== 1'b1 || e.v !== 1'b0) begin
         failures++;
         $display("[TB] FAIL post_reset_uflow got=%h/%b/%b exp=0000/0/1", sample, sample_valid, underflow);
      end
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 16'h0000;
      done     = 1'b0;
      test_reset();
      test_fill_drain();
      test_underflow();
      test_long_done_enable();
      test_simultaneous();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
